// File: rtl/lab3_pkg.sv
// Shared encodings, widths and helpers for the lab3 LED sequencing controller.
package lab3_pkg;

  localparam int NUM_BTN = 4;
  localparam int NUM_LED = 6;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    HOLD  = 2'd1,
    BLINK = 2'd2,
    CHASE = 2'd3
  } mode_e;

  localparam logic [NUM_LED-1:0] CHASE_INIT = 6'b000001;
  localparam logic               DIR_LEFT   = 1'b0;
  localparam logic               DIR_RIGHT  = 1'b1;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      PASS:    return HOLD;
      HOLD:    return BLINK;
      BLINK:   return CHASE;
      default: return PASS;
    endcase
  endfunction

  // Left moves toward bit5 and wraps to bit0; right is the mirror image.
  function automatic logic [NUM_LED-1:0] chase_step(input logic [NUM_LED-1:0] pat,
                                                    input logic dir);
    if (dir == DIR_RIGHT) return {pat[0], pat[NUM_LED-1:1]};
    return {pat[NUM_LED-2:0], pat[NUM_LED-1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, consecutive-cycle debounce counter and
// a one-cycle pulse on each clean rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic clean_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             prev_q;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    // Toggle on the cycle the count would reach DEBOUNCE_CYCLES; any agreement clears it.
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) clean_d = ~clean_q;
      else                                      cnt_d   = cnt_q + CNT_W'(1);
    end
    press_d = clean_q & ~prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      prev_q  <= clean_q;
      press_q <= press_d;
    end
  end

  assign clean_o = clean_q;
  assign press_o = press_q;

endmodule

// File: rtl/lab3_led_ctrl.sv
// Button conditioning for lab3 plus a display-mode FSM choosing live, frozen,
// blinking or chase content for the physical LEDs.
module lab3_led_ctrl
  import lab3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV       = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BUTTONS,
  input  logic [NUM_LED-1:0] LOGIC_LEDS,
  output logic [NUM_BTN-1:0] BTN_CLEAN,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [1:0]         MODE,
  output logic [NUM_LED-1:0] LEDS
);

  localparam int TICK_W = $clog2(BLINK_DIV);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (BUTTONS[i]),
      .clean_o(BTN_CLEAN[i]),
      .press_o(PRESS[i])
    );
  end

  mode_e               mode_q, mode_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                phase_q, phase_d;
  logic                dir_q, dir_d;
  logic [NUM_LED-1:0]  pat_q, pat_d;
  logic [NUM_LED-1:0]  snap_q, snap_d;
  logic [NUM_LED-1:0]  leds_q, leds_d;
  logic                wrap;

  always_comb begin
    mode_d  = mode_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    pat_d   = pat_q;
    snap_d  = snap_q;
    leds_d  = leds_q;
    wrap    = (tick_q == TICK_W'(BLINK_DIV - 1));

    if (PRESS[3]) begin
      // Mode change restarts every pattern; LEDS immediately take the new mode's content.
      mode_d  = next_mode(mode_q);
      tick_d  = '0;
      phase_d = 1'b1;
      dir_d   = DIR_LEFT;
      pat_d   = CHASE_INIT;
      case (mode_d)
        PASS:    leds_d = LOGIC_LEDS;
        HOLD: begin
          snap_d = leds_q;
          leds_d = leds_q;
        end
        BLINK:   leds_d = snap_q;
        default: leds_d = CHASE_INIT;
      endcase
    end else begin
      case (mode_q)
        PASS: begin
          tick_d = '0;
          leds_d = LOGIC_LEDS;
        end
        HOLD: begin
          tick_d = '0;
          if (PRESS[0]) snap_d = LOGIC_LEDS;
          leds_d = snap_d;
        end
        BLINK: begin
          if (PRESS[0]) snap_d = LOGIC_LEDS;
          if (wrap) begin
            tick_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          leds_d = phase_d ? snap_d : '0;
        end
        default: begin
          // Direction flip only steers the next step; the pattern holds still on the press.
          if (PRESS[1]) dir_d = ~dir_q;
          if (wrap) begin
            tick_d = '0;
            pat_d  = chase_step(pat_q, dir_d);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          leds_d = pat_d;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_q  <= PASS;
      tick_q  <= '0;
      phase_q <= 1'b1;
      dir_q   <= DIR_LEFT;
      pat_q   <= CHASE_INIT;
      snap_q  <= '0;
      leds_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      snap_q  <= snap_d;
      leds_q  <= leds_d;
    end
  end

  assign MODE = mode_q;
  assign LEDS = leds_q;

endmodule

// File: tb/tb_lab3_led_ctrl.sv
// Scoreboard bench for lab3_led_ctrl: expectations are queued with their due cycle
// when stimulus is applied and compared on the falling edge of that cycle.
module tb_lab3_led_ctrl;

  localparam int SIG_LEDS  = 0;
  localparam int SIG_MODE  = 1;
  localparam int SIG_CLEAN = 2;
  localparam int SIG_PRESS = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] BUTTONS;
  logic [5:0] LOGIC_LEDS;
  logic [3:0] BTN_CLEAN;
  logic [3:0] PRESS;
  logic [1:0] MODE;
  logic [5:0] LEDS;

  typedef struct {
    int         cyc;
    int         sig;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   e_chase;

  lab3_led_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV      (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUTTONS   (BUTTONS),
    .LOGIC_LEDS(LOGIC_LEDS),
    .BTN_CLEAN (BTN_CLEAN),
    .PRESS     (PRESS),
    .MODE      (MODE),
    .LEDS      (LEDS)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int dc, input int sig, input logic [5:0] val);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].sig)
          SIG_LEDS:  chk("leds", LEDS, sb[i].val);
          SIG_MODE:  chk("mode", {4'b0, MODE}, sb[i].val);
          SIG_CLEAN: chk("btn_clean", {2'b0, BTN_CLEAN}, sb[i].val);
          default:   chk("press", {2'b0, PRESS}, sb[i].val);
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Hold a button set long enough to debounce, then release and let it settle.
  task automatic tap(input logic [3:0] mask, input logic [1:0] m_old, input logic [1:0] m_new);
    push(7, SIG_PRESS, {2'b0, mask});
    push(8, SIG_PRESS, 6'd0);
    push(7, SIG_MODE, {4'b0, m_old});
    push(8, SIG_MODE, {4'b0, m_new});
    BUTTONS = mask;
    step(12);
    BUTTONS = 4'b0;
    step(12);
  endtask

  function automatic logic [5:0] chase_exp(input int n);
    int b;
    b = (n <= 6) ? (n % 6) : ((12 - n) % 6);
    return 6'(1 << b);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    BUTTONS    = 4'b0;
    LOGIC_LEDS = 6'b0;
    step(2);
    chk("rst_leds", LEDS, 6'd0);
    chk("rst_mode", {4'b0, MODE}, 6'd0);
    chk("rst_clean", {2'b0, BTN_CLEAN}, 6'd0);
    chk("rst_press", {2'b0, PRESS}, 6'd0);
    RESET = 1'b0;
    step(2);

    // PASS: one-cycle latency
    LOGIC_LEDS = 6'b101010;
    push(0, SIG_LEDS, 6'b000000);
    push(1, SIG_LEDS, 6'b101010);
    step(1);
    LOGIC_LEDS = 6'b010101;
    push(0, SIG_LEDS, 6'b101010);
    push(1, SIG_LEDS, 6'b010101);
    step(2);

    // Debounce: 3-cycle glitch rejected
    BUTTONS[0] = 1'b1;
    for (int d = 1; d <= 10; d++) begin
      push(d, SIG_CLEAN, 6'd0);
      push(d, SIG_PRESS, 6'd0);
    end
    step(3);
    BUTTONS[0] = 1'b0;
    step(12);

    // Debounce: 12-cycle hold accepted, release gives no pulse
    BUTTONS[0] = 1'b1;
    push(5, SIG_CLEAN, 6'd0);
    push(6, SIG_CLEAN, 6'd1);
    push(6, SIG_PRESS, 6'd0);
    push(7, SIG_PRESS, 6'd1);
    push(8, SIG_PRESS, 6'd0);
    step(12);
    BUTTONS[0] = 1'b0;
    push(5, SIG_CLEAN, 6'd1);
    push(6, SIG_CLEAN, 6'd0);
    for (int d = 0; d <= 8; d++) push(d, SIG_PRESS, 6'd0);
    step(12);

    // Mode cycling
    tap(4'b1000, 2'd0, 2'd1);
    tap(4'b1000, 2'd1, 2'd2);
    tap(4'b1000, 2'd2, 2'd3);
    tap(4'b1000, 2'd3, 2'd0);

    // HOLD freezes LEDS, PRESS[0] reloads the snapshot
    tap(4'b1000, 2'd0, 2'd1);
    LOGIC_LEDS = 6'b001101;
    push(2, SIG_LEDS, 6'b010101);
    push(7, SIG_LEDS, 6'b010101);
    push(8, SIG_LEDS, 6'b001101);
    tap(4'b0001, 2'd1, 2'd1);

    // PRESS[3] with PRESS[0]: mode advances, snapshot untouched, then blinks
    LOGIC_LEDS = 6'b111111;
    push(7, SIG_LEDS, 6'b001101);
    for (int d = 8; d < 32; d++)
      push(d, SIG_LEDS, (((d - 8) / 8) % 2 == 0) ? 6'b001101 : 6'b000000);
    tap(4'b1001, 2'd1, 2'd2);

    // CHASE: left wrap, then reverse while at 000001
    e_chase = cyc + 8;
    for (int d = 8; d < 90; d++) push(d, SIG_LEDS, chase_exp((d - 8) / 8));
    tap(4'b1000, 2'd2, 2'd3);
    step(e_chase + 44 - cyc);
    tap(4'b0010, 2'd3, 2'd3);

    // Give lab3 a held button so reset visibly clears BTN_CLEAN
    step(e_chase + 70 - cyc);
    BUTTONS[2] = 1'b1;
    push(6, SIG_CLEAN, 6'b000100);
    push(7, SIG_PRESS, 6'b000100);
    push(8, SIG_PRESS, 6'd0);
    step(e_chase + 82 - cyc);

    // Asynchronous reset between edges
    #1;
    chk("pre_rst_leds", LEDS, 6'b000100);
    chk("pre_rst_clean", {2'b0, BTN_CLEAN}, 6'b000100);
    RESET = 1'b1;
    #1;
    chk("async_rst_leds", LEDS, 6'd0);
    chk("async_rst_mode", {4'b0, MODE}, 6'd0);
    chk("async_rst_clean", {2'b0, BTN_CLEAN}, 6'd0);
    BUTTONS = 4'b0;
    step(2);
    LOGIC_LEDS = 6'b110011;
    push(0, SIG_LEDS, 6'd0);
    push(0, SIG_MODE, 6'd0);
    push(1, SIG_LEDS, 6'b110011);
    push(1, SIG_MODE, 6'd0);
    RESET = 1'b0;
    step(3);

    chk("sb_left", 6'(sb.size()), 6'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
